multicycle_control_fsm: RTL

//  Moore-style sequencer for the multi-cycle build of the MIPS-subset core (R-type, lw, sw, beq, j).

---
 rtl/multicycle_control_fsm.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-subset control sequencer (R-type, lw, sw, beq, j).
// This is a Moore FSM. The datapath controls are decoded from the registered
// state. The only exceptions are the FETCH pc_write/ir_write strobes, which
// wait for mem_ready. A per-state wait counter traps memory stalls that run
// too long.
module multicycle_control_fsm #(
  parameter int OPCODE_SIZE = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic [3:0]             state,
  output logic                   trap
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [OPCODE_SIZE-1:0] OP_RTYPE = OPCODE_SIZE'(6'b000000);
  localparam logic [OPCODE_SIZE-1:0] OP_LW    = OPCODE_SIZE'(6'b100011);
  localparam logic [OPCODE_SIZE-1:0] OP_SW    = OPCODE_SIZE'(6'b101011);
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ   = OPCODE_SIZE'(6'b000100);
  localparam logic [OPCODE_SIZE-1:0] OP_J     = OPCODE_SIZE'(6'b000010);

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    TRAP   = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               is_lw_q, is_lw_d;
  logic               waiting;
  logic               timeout;
  state_e             instr_end;

  // Memory-handshake states are the only states that stall. They are also
  // the only states where the wait counter advances.
  assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

  // Timeout applies only while memory is still not ready. mem_ready in the
  // final allowed cycle takes priority, so the FSM advances normally.
  assign timeout = waiting && !mem_ready &&
                   (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // run is looked at only at an instruction boundary. An instruction that is
  // already in flight always completes.
  assign instr_end = run ? FETCH : IDLE;

  // State, wait counter and latched lw/sw selector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      is_lw_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      is_lw_q    <= is_lw_d;
    end
  end

  // Next-state selection. The opcode is sampled only in DECODE. MEMADR picks
  // between MEMRD and MEMWR from the bit latched during DECODE.
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ready)    state_d = DECODE;
        else if (timeout) state_d = TRAP;
      end
      DECODE: begin
        is_lw_d = (opcode == OP_LW);
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = MEMADR;
        else if (opcode == OP_RTYPE)                state_d = EXEC;
        else if (opcode == OP_BEQ)                  state_d = BRANCH;
        else if (opcode == OP_J)                    state_d = JUMP;
        else                                        state_d = TRAP;
      end
      MEMADR: begin
        state_d = is_lw_q ? MEMRD : MEMWR;
      end
      MEMRD: begin
        if (mem_ready)    state_d = MEMWB;
        else if (timeout) state_d = TRAP;
      end
      MEMWB: begin
        state_d = instr_end;
      end
      MEMWR: begin
        if (mem_ready)    state_d = instr_end;
        else if (timeout) state_d = TRAP;
      end
      EXEC: begin
        state_d = ALUWB;
      end
      ALUWB, BRANCH, JUMP: begin
        state_d = instr_end;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  // Wait counter. It restarts on every state change and counts the
  // not-ready cycles spent in a handshake state.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (waiting && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Moore control decode from the registered state. Only the FETCH PC/IR
  // strobes are qualified by mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    trap          = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMMSH2;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = state_q;

endmodule
